// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS ops into 32-bit words and tags each with a sequential address.
// Words sit in a 2-entry register FIFO. Optional rd/rt=0 rejection: MIPS_ENC_DEST0_CHECK_EN.
module mips_instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_dest0
);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   logic [1:0]        count;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       s1_instr;
   logic [ADDR_W-1:0] s1_addr;
   logic [31:0]       enc;
   logic              bad;
   logic              accept;
   logic              push;
   logic              pop;

   always_comb begin
      enc = '0;
      case (in_kind)
         3'd0: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
         3'd1: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
         3'd2: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
         3'd3: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
         3'd4: enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
         3'd5: enc = {6'b100011, in_rs, in_rt, in_imm};
         3'd6: enc = {6'b101011, in_rs, in_rt, in_imm};
         default: enc = {6'b000100, in_rs, in_rt, in_imm};
      endcase
   end

   // Ready depends only on stored occupancy, never on the consumer side.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && !bad;
   assign pop       = out_valid && out_ready;

`ifdef MIPS_ENC_DEST0_CHECK_EN
   assign bad = ((in_kind <= 3'd4) && (in_rd == 5'd0)) ||
                ((in_kind == 3'd5) && (in_rt == 5'd0));

   always_ff @(posedge clk) begin
      if (rst || clear) err_dest0 <= 1'b0;
      else              err_dest0 <= accept && bad;
   end
`else
   assign bad       = 1'b0;
   assign err_dest0 = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= 2'd0;
         wr_addr   <= BASE;
         out_instr <= '0;
         out_addr  <= BASE;
         s1_instr  <= '0;
         s1_addr   <= BASE;
      end else if (clear) begin
         count   <= 2'd0;
         wr_addr <= BASE;
      end else begin
         if (push) wr_addr <= wr_addr + ADDR_W'(1);
         case (count)
            2'd0: begin
               if (push) begin
                  out_instr <= enc;
                  out_addr  <= wr_addr;
                  count     <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  out_instr <= enc;
                  out_addr  <= wr_addr;
               end else if (push) begin
                  s1_instr <= enc;
                  s1_addr  <= wr_addr;
                  count    <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            default: begin
               // Full: the second slot moves up to the head on a pop.
               if (pop) begin
                  out_instr <= s1_instr;
                  out_addr  <= s1_addr;
                  count     <= 2'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed steps plus random traffic against a queue model.
module tb_mips_instr_encoder;
   logic        clk = 1'b0;
   logic        rst = 1'b0, clr = 1'b0, iv = 1'b0, ordy = 1'b0;
   logic [2:0]  ik = '0;
   logic [4:0]  irs = '0, irt = '0, ird = '0;
   logic [15:0] iimm = '0;
   logic        in_ready, out_valid, err_dest0;
   logic [31:0] out_instr;
   logic [7:0]  out_addr;
   logic        in_ready2, out_valid2, err_dest02;
   logic [31:0] out_instr2;
   logic [1:0]  out_addr2;

   int total = 0;
   int bad = 0;

   typedef struct { logic [31:0] w; int a; } ent_t;
   ent_t q[$];
   int   wa = 0;
   bit   err_exp = 0;
   bit   armed = 0;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .clear(clr), .in_valid(iv), .in_ready(in_ready),
      .in_kind(ik), .in_rs(irs), .in_rt(irt), .in_rd(ird), .in_imm(iimm),
      .out_valid(out_valid), .out_ready(ordy), .out_instr(out_instr),
      .out_addr(out_addr), .err_dest0(err_dest0));

   mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
      .clk(clk), .rst(rst), .clear(clr), .in_valid(iv), .in_ready(in_ready2),
      .in_kind(ik), .in_rs(irs), .in_rt(irt), .in_rd(ird), .in_imm(iimm),
      .out_valid(out_valid2), .out_ready(ordy), .out_instr(out_instr2),
      .out_addr(out_addr2), .err_dest0(err_dest02));

   function automatic logic [31:0] ref_enc(int k, int rs, int rt, int rd, int imm);
      int fn [0:4];
      int opc [0:2];
      fn  = '{32, 34, 36, 37, 42};
      opc = '{35, 43, 4};
      if (k < 5) return 32'(rs * (2**21) + rt * (2**16) + rd * (2**11) + fn[k]);
      return 32'(opc[k-5]) * 32'(2**26) + 32'(rs * (2**21) + rt * (2**16) + imm);
   endfunction

   function automatic bit ref_bad(int k, int rt, int rd);
`ifdef MIPS_ENC_DEST0_CHECK_EN
      return (k < 5 && rd == 0) || (k == 5 && rt == 0);
`else
      return 0;
`endif
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(bit v, int k, int rs, int rt, int rd, int imm, bit r);
      iv = v; ik = 3'(k); irs = 5'(rs); irt = 5'(rt); ird = 5'(rd);
      iimm = 16'(imm); ordy = r;
   endtask

   // One clock: compare outputs with the model at negedge, then advance the model.
   task automatic cyc();
      bit acc, pp, isbad;
      @(negedge clk);
      if (armed) begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
         chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
         chk("err_dest0", {31'b0, err_dest0}, {31'b0, err_exp});
         chk("in_ready2", {31'b0, in_ready2}, {31'b0, q.size() < 2});
         if (q.size() != 0) begin
            chk("out_instr", out_instr, q[0].w);
            chk("out_addr", {24'b0, out_addr}, 32'(q[0].a));
            chk("out_addr2", {30'b0, out_addr2}, 32'(q[0].a % 4));
         end
      end
      acc   = iv && (q.size() < 2);
      pp    = (q.size() != 0) && ordy;
      isbad = ref_bad(int'(ik), int'(irt), int'(ird));
      @(posedge clk);
      #1;
      err_exp = 0;
      if (rst || clr) begin
         q.delete();
         wa = 0;
      end else begin
         if (pp) void'(q.pop_front());
         if (acc && !isbad) begin
            q.push_back('{ref_enc(int'(ik), int'(irs), int'(irt), int'(ird), int'(iimm)), wa});
            wa = (wa + 1) % 256;
         end
         err_exp = acc && isbad;
      end
      if (rst) armed = 1;
   endtask

   initial begin
      // reset state
      rst = 1; cyc(); cyc(); rst = 0;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr", {24'b0, out_addr}, 32'd0);
      chk("rst_err", {31'b0, err_dest0}, 32'd0);

      // single ADD, one-cycle latency
      req(1, 0, 1, 2, 3, 0, 0); cyc();
      chk("add_valid", {31'b0, out_valid}, 32'd1);
      chk("add_word", out_instr, 32'h00221820);
      chk("add_addr", {24'b0, out_addr}, 32'd0);
      req(0, 0, 0, 0, 0, 0, 1); cyc();

      // fill to two, third push refused
      rst = 1; cyc(); rst = 0;
      req(1, 5, 4, 5, 0, 16'h0010, 0); cyc();
      req(1, 7, 1, 2, 0, 16'hFFFF, 0); cyc();
      chk("full_ready", {31'b0, in_ready}, 32'd0);
      chk("lw_word", out_instr, 32'h8C850010);
      chk("lw_addr", {24'b0, out_addr}, 32'd0);
      req(1, 6, 29, 31, 0, 4, 0); cyc();

      // drain while SW keeps offering
      req(1, 6, 29, 31, 0, 4, 1); cyc();
      chk("beq_word", out_instr, 32'h1022FFFF);
      chk("beq_addr", {24'b0, out_addr}, 32'd1);
      cyc();
      chk("sw_word", out_instr, 32'hAFBF0004);
      chk("sw_addr", {24'b0, out_addr}, 32'd2);
      req(0, 0, 0, 0, 0, 0, 1); cyc(); cyc();

      // clear then reset with a full buffer and a concurrent request
      for (int pass = 0; pass < 2; pass++) begin
         req(1, 0, 1, 2, 3, 0, 0); cyc();
         req(1, 1, 4, 5, 6, 0, 0); cyc();
         req(1, 2, 7, 8, 9, 0, 0);
         if (pass == 0) clr = 1; else rst = 1;
         cyc();
         clr = 0; rst = 0;
         chk("flush_valid", {31'b0, out_valid}, 32'd0);
         chk("flush_ready", {31'b0, in_ready}, 32'd1);
         req(1, 3, 1, 2, 3, 0, 0); cyc();
         chk("flush_addr", {24'b0, out_addr}, 32'd0);
         req(0, 0, 0, 0, 0, 0, 1); cyc();
      end

      // OR with rd=0
      rst = 1; cyc(); rst = 0;
      req(1, 3, 5, 6, 0, 0, 0); cyc();
      req(0, 0, 0, 0, 0, 0, 0);
`ifdef MIPS_ENC_DEST0_CHECK_EN
      chk("dest0_err", {31'b0, err_dest0}, 32'd1);
      chk("dest0_valid", {31'b0, out_valid}, 32'd0);
      cyc();
      chk("dest0_err_clr", {31'b0, err_dest0}, 32'd0);
      req(1, 0, 1, 2, 3, 0, 0); cyc();
      chk("dest0_next_addr", {24'b0, out_addr}, 32'd0);
`else
      chk("dest0_word", out_instr, 32'h00A60025);
      chk("dest0_err", {31'b0, err_dest0}, 32'd0);
`endif
      req(0, 0, 0, 0, 0, 0, 1); cyc();

      // narrow address counter wraps to 0
      rst = 1; cyc(); rst = 0;
      for (int i = 0; i < 5; i++) begin
         req(1, 0, i + 1, 2, 3, 0, 0); cyc();
         chk("wrap_addr2", {30'b0, out_addr2}, 32'(i % 4));
         req(0, 0, 0, 0, 0, 0, 1); cyc();
      end

      // random traffic
      for (int n = 0; n < 600; n++) begin
         req($urandom % 2, $urandom % 8, $urandom % 32,
             ($urandom % 4 == 0) ? 0 : $urandom % 32,
             ($urandom % 4 == 0) ? 0 : $urandom % 32,
             $urandom % 65536, ($urandom % 3) != 0);
         rst = ($urandom % 60 == 0);
         clr = ($urandom % 40 == 0);
         cyc();
      end
      rst = 0; clr = 0;
      req(0, 0, 0, 0, 0, 0, 0); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
